case_1_product_acc: RTL and testbench
=====================================

CASE_1_PRODUCT_ACC -- requirements
Module: case_1_product_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 4: signed product width from the upstream multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 12: signed accumulator and result width; legal only if ACC_WIDTH >= DIN_WIDTH.
REQ-003 SHALL have parameter LEN, default 8: products per result; legal only if LEN >= 2.
REQ-004 SHALL have port ap_clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous abort of the current accumulation.
REQ-007 SHALL have port din_tdata, input, DIN_WIDTH bits: signed product.
REQ-008 SHALL have port din_tvalid, input, 1 bit: din_tdata is valid.
REQ-009 SHALL have port din_tready, output, 1 bit: block accepts a product.
REQ-010 SHALL have port dout_tdata, output, ACC_WIDTH bits: signed sum of LEN products.
REQ-011 SHALL have port dout_sat, output, 1 bit: result was clamped.
REQ-012 SHALL have port dout_tvalid, output, 1 bit: result is valid.
REQ-013 SHALL have port dout_tready, input, 1 bit: downstream accepts the result.

Function
REQ-014 SHALL implement a two-state FSM, ACC and OUT; the reset state is ACC.
REQ-015 In ACC, din_tready SHALL be 1 and dout_tvalid SHALL be 0.
REQ-016 In OUT, din_tready SHALL be 0 and dout_tvalid SHALL be 1.
REQ-017 An input handshake (din_tvalid & din_tready) SHALL add sign-extended din_tdata to acc and increment cnt (range 0..LEN-1).
REQ-018 The handshake with cnt==LEN-1 SHALL register acc+din into dout_tdata, zero cnt, and enter OUT; the result SHALL be visible one cycle after the last input handshake.
REQ-019 In OUT, dout_tdata and dout_sat SHALL hold stable until dout_tready=1.
REQ-020 An output handshake SHALL zero acc and dout_sat and return to ACC; no input is accepted in the same cycle. Sustained throughput is one result per LEN+1 cycles.
REQ-021 clr=1 SHALL, at the next edge, zero acc, cnt and the sat flag, force ACC, and drop dout_tvalid; clr SHALL take priority over any simultaneous input or output handshake, and the product presented in that cycle SHALL be discarded.
REQ-022 din_tvalid low SHALL stall accumulation indefinitely with no loss of state.
REQ-023 Arithmetic SHALL be two's complement at ACC_WIDTH; overflow behaviour is set per REQ-026/REQ-027.

Reset
REQ-024 While ap_rst_n=0, outputs SHALL be: din_tready=0, dout_tvalid=0, dout_tdata=0, dout_sat=0; internally acc=0, cnt=0, state ACC.
REQ-025 din_tready SHALL rise in the first cycle after reset deassertion. Reset asserted mid-accumulation or in OUT SHALL discard all partial state without emitting a result.

Configuration
REQ-026 With CASE_1_PRODUCT_ACC_SAT_EN defined, every addition SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; any clamp SHALL set a sticky flag that is reported on dout_sat for that result.
REQ-027 Without CASE_1_PRODUCT_ACC_SAT_EN, additions SHALL wrap modulo 2^ACC_WIDTH and dout_sat SHALL be constant 0.

Structure
REQ-028 Package case_1_pkg SHALL hold the FSM state typedef and the default DIN_WIDTH, ACC_WIDTH and LEN constants.
REQ-029 The add-with-optional-clamp SHALL be a combinational sub-module, case_1_sat_add (inputs a, b, sat_en; outputs sum, sat).

Verification
REQ-030 Sequence test: defaults, products 1,-2,3,-4,5,-6,7,-8 back-to-back -> dout_tdata=-4, dout_tvalid rises one cycle after the 8th handshake, dout_sat=0.
REQ-031 Backpressure test: dout_tready=0 for 5 cycles after a result -> dout_tdata stable, din_tready=0 throughout, no input is accepted.
REQ-032 Wrap vs saturate test: ACC_WIDTH=6, eight products of 7 -> without the macro dout_tdata=-8 (56 wraps); with the macro dout_tdata=31 and dout_sat=1.
REQ-033 Clear test: clr pulse after 3 handshakes, then eight products of -1 -> dout_tdata=-8.
REQ-034 Reset test: ap_rst_n low while in OUT -> dout_tvalid=0 asynchronously; after release, eight products of 2 -> dout_tdata=16.
REQ-035 Bubble test: random din_tvalid gaps with products of 1 -> every result equals LEN (8).

Source files
------------

// File: rtl/case_1_pkg.sv
// Shared types and default sizing for the product accumulator.
//   state_t        : FSM state encoding (ST_ACC collecting, ST_OUT holding a result)
//   DEF_DIN_WIDTH  : default signed product width
//   DEF_ACC_WIDTH  : default signed accumulator / result width
//   DEF_LEN        : default number of products summed per result
package case_1_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam int DEF_DIN_WIDTH = 4;
  localparam int DEF_ACC_WIDTH = 12;
  localparam int DEF_LEN       = 8;

endpackage

// File: rtl/case_1_sat_add.sv
// Combinational two's complement adder with optional clamping.
//   W      : operand / result width
//   a, b   : signed operands (W bits)
//   sat_en : 1 = clamp on overflow, 0 = wrap modulo 2^W
//   sum    : result (W bits)
//   sat    : 1 when the result was clamped (always 0 when sat_en = 0)
module case_1_sat_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sat_en,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W-1:0] w_raw;
  logic         w_ovf;

  assign w_raw = a + b;
  // Signed overflow only when both operands share a sign the result lost.
  assign w_ovf = (a[W-1] == b[W-1]) && (w_raw[W-1] != a[W-1]);
  assign sat   = sat_en & w_ovf;

  // On overflow the operand sign says which rail was crossed.
  always_comb begin
    sum = w_raw;
    if (sat) sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/case_1_product_acc.sv
// Streaming accumulator: sums LEN signed products into one signed result.
// Optional feature macro: CASE_1_PRODUCT_ACC_SAT_EN (clamp every addition and
// report a sticky clamp flag on dout_sat); default build wraps, dout_sat = 0.
//   ap_clk      : clock, rising edge
//   ap_rst_n    : asynchronous active-low reset
//   clr         : synchronous abort of the current accumulation
//   din_tdata   : signed product (DIN_WIDTH)
//   din_tvalid  : product valid
//   din_tready  : product accepted (ACC state)
//   dout_tdata  : signed sum of LEN products (ACC_WIDTH)
//   dout_sat    : result was clamped
//   dout_tvalid : result valid (OUT state)
//   dout_tready : downstream accepts the result
module case_1_product_acc
  import case_1_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int LEN       = DEF_LEN
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clr,
  input  logic [DIN_WIDTH-1:0] din_tdata,
  input  logic                 din_tvalid,
  output logic                 din_tready,
  output logic [ACC_WIDTH-1:0] dout_tdata,
  output logic                 dout_sat,
  output logic                 dout_tvalid,
  input  logic                 dout_tready
);

  localparam int              CNT_W    = $clog2(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

`ifdef CASE_1_PRODUCT_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  generate
    if (ACC_WIDTH < DIN_WIDTH) begin : g_bad_width
      $error("ACC_WIDTH must be >= DIN_WIDTH");
    end
    if (LEN < 2) begin : g_bad_len
      $error("LEN must be >= 2");
    end
  endgenerate

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sat;
  logic [ACC_WIDTH-1:0] r_dout_tdata;
  logic                 r_dout_sat;
  logic                 r_din_tready;
  logic                 r_dout_tvalid;

  logic [ACC_WIDTH-1:0] w_din_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_sat;
  logic                 w_in_hs;

  assign w_din_ext = ACC_WIDTH'($signed(din_tdata));
  assign w_in_hs   = din_tvalid & r_din_tready;

  case_1_sat_add #(.W(ACC_WIDTH)) u_add (
    .a      (r_acc),
    .b      (w_din_ext),
    .sat_en (SAT_EN),
    .sum    (w_sum),
    .sat    (w_add_sat)
  );

  // din_tready comes out of reset low and rises on the first edge after
  // release, so an upstream source never sees a handshake during reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= ST_ACC;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_sat         <= 1'b0;
      r_dout_tdata  <= '0;
      r_dout_sat    <= 1'b0;
      r_din_tready  <= 1'b0;
      r_dout_tvalid <= 1'b0;
    end else if (clr) begin
      // Abort wins over both handshakes; the product on din is dropped.
      r_state       <= ST_ACC;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_sat         <= 1'b0;
      r_dout_sat    <= 1'b0;
      r_din_tready  <= 1'b1;
      r_dout_tvalid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          r_din_tready <= 1'b1;
          if (w_in_hs) begin
            if (r_cnt == CNT_LAST) begin
              r_dout_tdata  <= w_sum;
              r_dout_sat    <= r_sat | w_add_sat;
              r_acc         <= '0;
              r_sat         <= 1'b0;
              r_cnt         <= '0;
              r_state       <= ST_OUT;
              r_din_tready  <= 1'b0;
              r_dout_tvalid <= 1'b1;
            end else begin
              r_acc <= w_sum;
              r_sat <= r_sat | w_add_sat;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_OUT: begin
          // Result holds until taken; the ACC return costs one cycle,
          // giving one result per LEN+1 cycles.
          if (dout_tready) begin
            r_state       <= ST_ACC;
            r_dout_sat    <= 1'b0;
            r_din_tready  <= 1'b1;
            r_dout_tvalid <= 1'b0;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign din_tready  = r_din_tready;
  assign dout_tvalid = r_dout_tvalid;
  assign dout_tdata  = r_dout_tdata;
  assign dout_sat    = r_dout_sat;

endmodule

// File: tb/tb_case_1_product_acc.sv
// Bench for case_1_product_acc: a default-width instance (ACC_WIDTH=12) and a
// narrow one (ACC_WIDTH=6) share all inputs so wrap/clamp behaviour is seen
// alongside the normal result. Directed table, hand sequences, then random.
module tb_case_1_product_acc;

`ifdef CASE_1_PRODUCT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  din_tdata = '0;
  logic        din_tvalid = 1'b0;
  logic        dout_tready = 1'b0;

  logic        a_din_tready, a_dout_sat, a_dout_tvalid;
  logic [11:0] a_dout_tdata;
  logic        b_din_tready, b_dout_sat, b_dout_tvalid;
  logic [5:0]  b_dout_tdata;

  int n_chk = 0;
  int n_pass = 0;

  always #5 ap_clk = ~ap_clk;

  case_1_product_acc #(.DIN_WIDTH(4), .ACC_WIDTH(12), .LEN(8)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
    .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tready(a_din_tready),
    .dout_tdata(a_dout_tdata), .dout_sat(a_dout_sat),
    .dout_tvalid(a_dout_tvalid), .dout_tready(dout_tready)
  );

  case_1_product_acc #(.DIN_WIDTH(4), .ACC_WIDTH(6), .LEN(8)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clr(clr),
    .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tready(b_din_tready),
    .dout_tdata(b_dout_tdata), .dout_sat(b_dout_sat),
    .dout_tvalid(b_dout_tvalid), .dout_tready(dout_tready)
  );

  typedef struct packed {
    logic [7:0][3:0] p;    // p[0] is pushed first
    int              e12;  // 12-bit result
    int              e6w;  // 6-bit result, wrapping build
    int              e6s;  // 6-bit result, clamping build
    logic            f6s;  // 6-bit clamp flag, clamping build
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: running sum with plain integers, then either clamp or fold
  // back into the signed w-bit range after every addition.
  function automatic void model(input logic [7:0][3:0] p, input int w,
                                output int res, output int sat);
    int acc = 0;
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    sat = 0;
    for (int i = 0; i < 8; i++) begin
      acc = acc + int'($signed(p[i]));
      if (SAT) begin
        if (acc > hi) begin acc = hi; sat = 1; end
        if (acc < lo) begin acc = lo; sat = 1; end
      end else begin
        if (acc > hi) acc = acc - (1 << w);
        if (acc < lo) acc = acc + (1 << w);
      end
    end
    res = acc;
  endfunction

  task automatic push(input logic [3:0] p, input int gap);
    int n = 0;
    repeat (gap) @(negedge ap_clk);
    @(negedge ap_clk);
    din_tdata = p;
    din_tvalid = 1'b1;
    while (!(a_din_tready && b_din_tready) && n < 40) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 40) chk("push_timeout", n, 0);
    @(posedge ap_clk);
    #1;
    din_tvalid = 1'b0;
  endtask

  task automatic run8(input string nm, input logic [7:0][3:0] p, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      push(p[i], $urandom_range(0, maxgap));
      if (i == 6) chk({nm, "_vld_early"}, a_dout_tvalid, 0);
    end
    chk({nm, "_vld_rise"}, a_dout_tvalid, 1);
  endtask

  task automatic pop(input string nm, input int ea, input int sa,
                     input int eb, input int sb, input int delay);
    int n = 0;
    @(negedge ap_clk);
    while (!(a_dout_tvalid && b_dout_tvalid) && n < 40) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 40) chk({nm, "_timeout"}, n, 0);
    repeat (delay) @(negedge ap_clk);
    chk({nm, "_a_data"}, int'($signed(a_dout_tdata)), ea);
    chk({nm, "_a_sat"}, a_dout_sat, sa);
    chk({nm, "_b_data"}, int'($signed(b_dout_tdata)), eb);
    chk({nm, "_b_sat"}, b_dout_sat, sb);
    dout_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    dout_tready = 1'b0;
    chk({nm, "_vld_drop"}, a_dout_tvalid, 0);
    chk({nm, "_rdy_back"}, a_din_tready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    logic [7:0][3:0] rp;
    int ea, sa, eb, sb;

    tbl[0] = '{p: 32'h87A5C3E1, e12: -4,  e6w: -4, e6s: -4,  f6s: 1'b0}; // 1,-2,..,-8
    tbl[1] = '{p: 32'h77777777, e12: 56,  e6w: -8, e6s: 31,  f6s: 1'b1};
    tbl[2] = '{p: 32'h88888888, e12: -64, e6w: 0,  e6s: -32, f6s: 1'b1};
    tbl[3] = '{p: 32'h22222222, e12: 16,  e6w: 16, e6s: 16,  f6s: 1'b0};
    tbl[4] = '{p: 32'h88877777, e12: 11,  e6w: 11, e6s: 7,   f6s: 1'b1}; // clamp is sticky

    // Reset state
    #3;
    chk("rst_din_tready", a_din_tready, 0);
    chk("rst_dout_tvalid", a_dout_tvalid, 0);
    chk("rst_dout_tdata", int'(a_dout_tdata), 0);
    chk("rst_dout_sat", a_dout_sat, 0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("rst_rel_din_tready", a_din_tready, 1);

    // Directed table, back-to-back inputs
    for (int v = 0; v < 5; v++) begin
      run8($sformatf("tbl%0d", v), tbl[v].p, 0);
      pop($sformatf("tbl%0d", v), tbl[v].e12, 0,
          SAT ? tbl[v].e6s : tbl[v].e6w, SAT ? int'(tbl[v].f6s) : 0, 0);
    end

    // Backpressure: result held, inputs refused
    run8("bp", 32'h11111111, 0);
    din_tdata = 4'd5;
    din_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      chk("bp_hold_data", int'($signed(a_dout_tdata)), 8);
      chk("bp_din_tready", a_din_tready, 0);
      chk("bp_hold_vld", a_dout_tvalid, 1);
    end
    din_tvalid = 1'b0;
    pop("bp", 8, 0, 8, 0, 0);
    run8("bp_next", 32'h11111111, 0);
    pop("bp_next", 8, 0, 8, 0, 0);

    // Clear after 3 handshakes; product presented with clr is dropped
    for (int i = 0; i < 3; i++) push(4'd7, 0);
    @(negedge ap_clk);
    clr = 1'b1;
    din_tdata = 4'd7;
    din_tvalid = 1'b1;
    @(posedge ap_clk);
    #1;
    clr = 1'b0;
    din_tvalid = 1'b0;
    chk("clr_vld", a_dout_tvalid, 0);
    run8("clr", 32'hFFFFFFFF, 0);
    pop("clr", -8, 0, -8, 0, 0);

    // Clear also drops a pending clamp flag
    for (int i = 0; i < 5; i++) push(4'd7, 0);
    @(negedge ap_clk);
    clr = 1'b1;
    @(posedge ap_clk);
    #1;
    clr = 1'b0;
    run8("clrsat", 32'h22222222, 0);
    pop("clrsat", 16, 0, 16, 0, 0);

    // Clear beats a simultaneous output handshake and drops the result
    run8("clrout", 32'h11111111, 0);
    @(negedge ap_clk);
    clr = 1'b1;
    dout_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    clr = 1'b0;
    dout_tready = 1'b0;
    chk("clrout_vld", a_dout_tvalid, 0);
    chk("clrout_rdy", a_din_tready, 1);
    run8("clrout_next", 32'h11111111, 0);
    pop("clrout_next", 8, 0, 8, 0, 0);

    // Reset while in OUT: outputs drop without waiting for a clock
    run8("rst_out", 32'h11111111, 0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_out_vld", a_dout_tvalid, 0);
    chk("rst_out_rdy", a_din_tready, 0);
    chk("rst_out_data", int'(a_dout_tdata), 0);
    chk("rst_out_sat", b_dout_sat, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("rst_out_rel_rdy", a_din_tready, 1);
    run8("rst_out_next", 32'h22222222, 0);
    pop("rst_out_next", 16, 0, 16, 0, 0);

    // Reset mid-accumulation discards the partial sum
    for (int i = 0; i < 4; i++) push(4'd7, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run8("rst_mid", 32'h22222222, 0);
    pop("rst_mid", 16, 0, 16, 0, 0);

    // Bubbles on din_tvalid never lose state
    for (int r = 0; r < 3; r++) begin
      run8($sformatf("bub%0d", r), 32'h11111111, 3);
      pop($sformatf("bub%0d", r), 8, 0, 8, 0, $urandom_range(0, 3));
    end

    // Random products, gaps and downstream delays against the model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) rp[i] = 4'($urandom_range(0, 15));
      model(rp, 12, ea, sa);
      model(rp, 6, eb, sb);
      run8($sformatf("rnd%0d", r), rp, 2);
      pop($sformatf("rnd%0d", r), ea, sa, eb, sb, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
